// File: rtl/npc_ras_if.sv
// npc_ras_if: controller-to-NPC bundle for npc_ras_unit.
// Carries exc_req only when NPC_EXC_EN is defined.
interface npc_ras_if #(
    parameter int RAS_DEPTH = 4,
    parameter int CNT_W     = 16
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;
    logic             stall;
    logic [2:0]       npc_op;
    logic [2:0]       br_type;
    logic [31:0]      cmp_a;
    logic [31:0]      cmp_b;
    logic [31:0]      offset;
    logic [25:0]      instr_index;
    logic [31:0]      reg_data;
    logic             is_call;
    logic             is_ret;
    logic [31:0]      pc;
    logic [31:0]      next_pc;
    logic             taken;
    logic [31:0]      ras_top;
    logic [CW-1:0]    ras_count;
    logic             ret_miss;
    logic [CNT_W-1:0] miss_cnt;
`ifdef NPC_EXC_EN
    logic             exc_req;
`endif
    modport master (
`ifdef NPC_EXC_EN
        output exc_req,
`endif
        output stall, npc_op, br_type, cmp_a, cmp_b, offset, instr_index, reg_data, is_call, is_ret,
        input  pc, next_pc, taken, ras_top, ras_count, ret_miss, miss_cnt
    );
    modport slave (
`ifdef NPC_EXC_EN
        input  exc_req,
`endif
        input  stall, npc_op, br_type, cmp_a, cmp_b, offset, instr_index, reg_data, is_call, is_ret,
        output pc, next_pc, taken, ras_top, ras_count, ret_miss, miss_cnt
    );
endinterface

// File: rtl/npc_ras_unit.sv
// npc_ras_unit: registered PC, next-PC select and return-address stack with miss counter.
// Optional exception redirect to EXC_VECTOR is enabled by defining NPC_EXC_EN.
module npc_ras_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int          RAS_DEPTH  = 4,
    parameter int          CNT_W      = 16,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input logic clk,
    input logic reset,
    npc_ras_if.slave bus
);
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;
    logic [31:0]      pc, p4, nxt, sel_pc;
    logic [31:0]      stack [RAS_DEPTH];
    logic [AW-1:0]    ptr, top_idx, wr_idx;
    logic [CW-1:0]    count;
    logic [CNT_W-1:0] miss_cnt;
    logic [7:0]       cond;
    logic             exc, empty, pop, ret_miss, taken, neg, zero;
`ifdef NPC_EXC_EN
    assign exc = bus.exc_req;
`else
    assign exc = 1'b0;
`endif
    // condition vector indexed directly by br_type; codes 6/7 are never taken
    always_comb begin
        neg      = bus.cmp_a[31];
        zero     = bus.cmp_a == 32'd0;
        cond     = {2'b00, ~neg, neg, ~(neg | zero), neg | zero,
                    bus.cmp_a != bus.cmp_b, bus.cmp_a == bus.cmp_b};
        taken    = (bus.npc_op == 3'b001) & cond[bus.br_type];
        p4       = pc + 32'd4;
        sel_pc   = (bus.npc_op == 3'b001) ? (taken ? p4 + (bus.offset << 2) : p4) :
                   (bus.npc_op == 3'b010) ? {pc[31:28], bus.instr_index, 2'b00} :
                   (bus.npc_op == 3'b011) ? bus.reg_data : p4;
        nxt      = exc ? EXC_VECTOR : sel_pc;
        top_idx  = ptr - AW'(1);
        empty    = count == '0;
        pop      = bus.is_ret & ~empty;
        ret_miss = bus.is_ret & (empty | (stack[top_idx] != bus.reg_data));
        // a call in the same cycle as a valid return overwrites the popped slot
        wr_idx   = pop ? top_idx : ptr;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            ptr      <= '0;
            count    <= '0;
            miss_cnt <= '0;
        end else if (!bus.stall) begin
            pc <= nxt;
            if (exc) begin
                count <= '0;
            end else begin
                ptr   <= ptr + AW'(bus.is_call) - AW'(pop);
                count <= (bus.is_call && !pop) ? ((count == CW'(RAS_DEPTH)) ? count : count + CW'(1)) :
                         (pop && !bus.is_call) ? count - CW'(1) : count;
                if (ret_miss && miss_cnt != '1)
                    miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset && !bus.stall && !exc && bus.is_call)
            stack[wr_idx] <= p4;
    end
    assign bus.pc        = pc;
    assign bus.next_pc   = nxt;
    assign bus.taken     = taken;
    assign bus.ras_top   = empty ? 32'd0 : stack[top_idx];
    assign bus.ras_count = count;
    assign bus.ret_miss  = ret_miss;
    assign bus.miss_cnt  = miss_cnt;
endmodule

// File: tb/tb_npc_ras_unit.sv
// tb_npc_ras_unit: directed and random checks of npc_ras_unit against a queue-based model.
// Exercises the exception redirect when NPC_EXC_EN is defined.
module tb_npc_ras_unit;
    localparam int          DEPTH  = 4;
    localparam int          CNT_W  = 16;
    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic exc_in;
    always #5 clk = ~clk;
    npc_ras_if #(.RAS_DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
    npc_ras_unit #(.RESET_PC(RST_PC), .RAS_DEPTH(DEPTH), .CNT_W(CNT_W), .EXC_VECTOR(EXC_PC))
        dut (.clk(clk), .reset(reset), .bus(bus));
`ifdef NPC_EXC_EN
    assign exc_in = bus.exc_req;
`else
    assign exc_in = 1'b0;
`endif
    int vectors = 0;
    int miscompares = 0;
    bit chk = 1'b0;
    logic [31:0]      m_pc;
    logic [31:0]      m_ras [$];
    logic [CNT_W-1:0] m_miss;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cond_true(input logic [2:0] bt, input logic [31:0] a, input logic [31:0] b);
        case (bt)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd2: return $signed(a) <= 0;
            3'd3: return $signed(a) > 0;
            3'd4: return $signed(a) < 0;
            3'd5: return $signed(a) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(3))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'($urandom_range(2)) - 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic idle();
        bus.stall = 0; bus.npc_op = 0; bus.br_type = 0; bus.cmp_a = 0; bus.cmp_b = 0;
        bus.offset = 0; bus.instr_index = 0; bus.reg_data = 0; bus.is_call = 0; bus.is_ret = 0;
`ifdef NPC_EXC_EN
        bus.exc_req = 0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // compare against the model on the falling edge, then advance the model for the next rising edge
    initial begin
        logic [31:0] p4, nxt, top;
        logic tk, empty, miss;
        forever begin
            @(negedge clk);
            p4    = m_pc + 32'd4;
            tk    = (bus.npc_op == 3'b001) && cond_true(bus.br_type, bus.cmp_a, bus.cmp_b);
            empty = m_ras.size() == 0;
            top   = empty ? 32'd0 : m_ras[$];
            miss  = bus.is_ret && (empty || top != bus.reg_data);
            case (bus.npc_op)
                3'b001:  nxt = tk ? p4 + (bus.offset << 2) : p4;
                3'b010:  nxt = {m_pc[31:28], bus.instr_index, 2'b00};
                3'b011:  nxt = bus.reg_data;
                default: nxt = p4;
            endcase
            if (exc_in) nxt = EXC_PC;
            if (chk) begin
                check("pc", bus.pc, m_pc);
                check("next_pc", bus.next_pc, nxt);
                check("taken", bus.taken, tk);
                check("ras_top", bus.ras_top, top);
                check("ras_count", bus.ras_count, m_ras.size());
                check("ret_miss", bus.ret_miss, miss);
                check("miss_cnt", bus.miss_cnt, m_miss);
            end
            if (reset) begin
                m_pc = RST_PC;
                m_ras.delete();
                m_miss = '0;
                chk = 1'b1;
            end else if (!bus.stall) begin
                m_pc = nxt;
                if (exc_in) begin
                    m_ras.delete();
                end else begin
                    if (bus.is_ret && !empty) void'(m_ras.pop_back());
                    if (bus.is_call) m_ras.push_back(p4);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                    if (miss && m_miss != '1) m_miss++;
                end
            end
        end
    end

    initial begin
        logic [15:0] imm;
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
        check("rst_pc", bus.pc, 32'h3000);
        check("rst_cnt", bus.ras_count, 0);
        check("rst_miss", bus.miss_cnt, 0);
        repeat (3) tick();
        check("p4_pc", bus.pc, 32'h300C);
        tick();
        check("p4_pc2", bus.pc, 32'h3010);
        bus.npc_op = 3'b001; bus.br_type = 3'd3; bus.cmp_a = 32'h8000_0000; bus.offset = 32'hFFFF_FFFC;
        #1 check("bgtz_neg_taken", bus.taken, 0);
        tick();
        check("bgtz_neg_pc", bus.pc, 32'h3014);
        bus.cmp_a = 32'd5;
        #1 check("bgtz_pos_taken", bus.taken, 1);
        tick();
        check("bgtz_pos_pc", bus.pc, 32'h3008);
        idle(); bus.npc_op = 3'b011; bus.reg_data = 32'h3020;
        tick();
        idle(); bus.npc_op = 3'b010; bus.is_call = 1; bus.instr_index = 26'h0000C40;
        tick();
        check("jal_pc", bus.pc, 32'h3100);
        check("jal_top", bus.ras_top, 32'h3024);
        idle(); bus.npc_op = 3'b011; bus.is_ret = 1; bus.reg_data = 32'h3024;
        #1 check("jr_miss", bus.ret_miss, 0);
        tick();
        check("jr_pc", bus.pc, 32'h3024);
        check("jr_cnt", bus.ras_count, 0);
        idle(); bus.npc_op = 3'b011; bus.reg_data = 32'h3000;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.is_call = 1;
            bus.reg_data = 32'h3100 + 32'(i) * 32'h100;
            tick();
        end
        check("full_cnt", bus.ras_count, 4);
        check("full_top", bus.ras_top, 32'h3404);
        bus.is_call = 0; bus.is_ret = 1;
        for (int i = 0; i < 4; i++) begin
            bus.reg_data = 32'h3404 - 32'(i) * 32'h100;
            #1 check("pop_hit", bus.ret_miss, 0);
            if (i == 3) check("pop4_top", bus.ras_top, 32'h3104);
            tick();
        end
        bus.reg_data = 32'h3500;
        #1 check("empty_pop_miss", bus.ret_miss, 1);
        tick();
        check("empty_pop_cnt", bus.miss_cnt, 1);
        check("empty_pop_ras", bus.ras_count, 0);
        idle(); bus.stall = 1; bus.is_call = 1; bus.npc_op = 3'b010;
        repeat (3) tick();
        check("stall_pc", bus.pc, 32'h3500);
        check("stall_cnt", bus.ras_count, 0);
        check("stall_miss", bus.miss_cnt, 1);
        reset = 1;
        tick();
        reset = 0;
        check("rst_stall_pc", bus.pc, 32'h3000);
        check("rst_stall_cnt", bus.ras_count, 0);
        idle();
`ifdef NPC_EXC_EN
        bus.npc_op = 3'b011; bus.reg_data = 32'h3000; bus.is_call = 1;
        tick();
        tick();
        check("exc_pre_cnt", bus.ras_count, 2);
        idle(); bus.exc_req = 1; bus.is_ret = 1; bus.reg_data = 32'hDEAD_BEEF;
        #1 check("exc_next", bus.next_pc, 32'h4180);
        tick();
        check("exc_pc", bus.pc, 32'h4180);
        check("exc_cnt", bus.ras_count, 0);
        check("exc_miss", bus.miss_cnt, 0);
        idle();
`endif
        for (int n = 0; n < 3000; n++) begin
            reset = $urandom_range(199) == 0;
            bus.stall = $urandom_range(7) == 0;
            bus.npc_op = 3'($urandom_range(7));
            bus.br_type = 3'($urandom_range(7));
            bus.cmp_a = pick();
            bus.cmp_b = ($urandom_range(1) == 0) ? bus.cmp_a : pick();
            imm = 16'($urandom);
            bus.offset = {{16{imm[15]}}, imm};
            bus.instr_index = 26'($urandom);
            bus.is_call = $urandom_range(3) == 0;
            bus.is_ret = $urandom_range(3) == 0;
            bus.reg_data = (m_ras.size() != 0 && $urandom_range(3) != 0) ? m_ras[$] : $urandom;
`ifdef NPC_EXC_EN
            bus.exc_req = $urandom_range(15) == 0;
`endif
            tick();
        end
        reset = 0;
        idle();
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
